// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared constants and state encoding for the load/store memory master
package lsu_pkg;

  localparam int LSU_DEPTH = 1024;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_MERGE,
    ST_RESP
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte/half lane extraction with extension, and sub-word store merge
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  input  logic [15:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] merged
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[{off, 3'b000} +: 8];
    lane_h = off[1] ? word[31:16] : word[15:0];
    rdata  = 32'h0;
    case (funct3)
      F3_B:    rdata = {{24{lane_b[7]}}, lane_b};
      F3_H:    rdata = {{16{lane_h[15]}}, lane_h};
      F3_W:    rdata = word;
      F3_BU:   rdata = {24'h0, lane_b};
      F3_HU:   rdata = {16'h0, lane_h};
      default: rdata = 32'h0;
    endcase
  end

  always_comb begin
    merged = word;
    case (funct3)
      F3_B: merged[{off, 3'b000} +: 8] = wdata[7:0];
      F3_H: begin
        if (off[1]) merged[31:16] = wdata;
        else        merged[15:0]  = wdata;
      end
      default: merged = word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - MEM-stage load/store initiator for a word-addressed data memory
// Sub-word stores are done as read-modify-write over two cycles.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int DEPTH = LSU_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  lsu_state_t       state;
  logic             we_q;
  logic [2:0]       f3_q;
  logic [IDX_W+1:0] addr_q;
  logic [31:0]      wdata_q;
  logic             req_err;
  logic [31:0]      ld_data;
  logic [31:0]      st_merged;

  // Decoded on the live request so an error can skip the memory entirely.
  always_comb begin
    req_err = 1'b0;
    case (req_funct3)
      F3_B:    req_err = 1'b0;
      F3_H:    req_err = req_addr[0];
      F3_W:    req_err = |req_addr[1:0];
      F3_BU:   req_err = req_we;
      F3_HU:   req_err = req_we | req_addr[0];
      default: req_err = 1'b1;
    endcase
    if (req_addr[31:2] >= 30'(DEPTH)) req_err = 1'b1;
  end

  lsu_align u_align (
    .word   (mem_rd),
    .off    (addr_q[1:0]),
    .funct3 (f3_q),
    .wdata  (wdata_q[15:0]),
    .rdata  (ld_data),
    .merged (st_merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      we_q       <= 1'b0;
      f3_q       <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      mem_we     <= 1'b0;
      mem_a      <= 32'h0;
      mem_wd     <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            f3_q      <= req_funct3;
            addr_q    <= req_addr[IDX_W+1:0];
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (req_err) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
              state      <= ST_RESP;
            end else begin
              mem_a <= {{(32-IDX_W){1'b0}}, req_addr[IDX_W+1:2]};
              // A full-word store needs no old data, so it writes in ACCESS.
              if (req_we && req_funct3 == F3_W) begin
                mem_we <= 1'b1;
                mem_wd <= req_wdata;
              end
              state <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          if (!we_q) begin
            resp_rdata <= ld_data;
            resp_valid <= 1'b1;
            mem_a      <= 32'h0;
            state      <= ST_RESP;
          end else if (f3_q == F3_W) begin
            mem_we     <= 1'b0;
            mem_wd     <= 32'h0;
            mem_a      <= 32'h0;
            resp_valid <= 1'b1;
            state      <= ST_RESP;
          end else begin
            mem_we <= 1'b1;
            mem_wd <= st_merged;
            state  <= ST_MERGE;
          end
        end
        ST_MERGE: begin
          mem_we     <= 1'b0;
          mem_wd     <= 32'h0;
          mem_a      <= 32'h0;
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
        default: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0;
          req_ready  <= 1'b1;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb/tb_lsu_mem_master.sv - randomized bench for lsu_mem_master against a behavioural load/store model
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic        ld_en = 1'b0;
  logic [9:0]  ld_idx = 10'd0;
  logic [31:0] ld_val = 32'h0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lsu_mem_master dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  assign mem_rd = mem[mem_a[9:0]];

  always @(posedge clk) begin
    if (ld_en) mem[ld_idx] <= ld_val;
    else if (mem_we) mem[mem_a[9:0]] <= mem_wd;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    ld_en  = 1'b1;
    ld_idx = 10'(idx);
    ld_val = val;
    ref_mem[idx] = val;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  // Reference behaviour straight from the RV32I load/store rules.
  function automatic bit model_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    bit e;
    e = 0;
    if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) e = 1;
    if (we && (f3 == 3'd4 || f3 == 3'd5)) e = 1;
    if ((f3 == 3'd1 || f3 == 3'd5) && a % 2 != 0) e = 1;
    if (f3 == 3'd2 && a % 4 != 0) e = 1;
    if (a / 4 >= 1024) e = 1;
    return e;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] w, input logic [31:0] a);
    logic [31:0] b, h;
    b = (w >> ((a % 4) * 8)) & 32'hFF;
    h = (w >> ((a % 4 >= 2) ? 16 : 0)) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
      3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_store(input logic [2:0] f3, input logic [31:0] w,
                                              input logic [31:0] a, input logic [31:0] wd);
    int sh;
    case (f3)
      3'd0: begin
        sh = (a % 4) * 8;
        return (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
      end
      3'd1: begin
        sh = (a % 4 >= 2) ? 16 : 0;
        return (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
      end
      default: return wd;
    endcase
  endfunction

  // Called on a negedge; returns on the negedge where resp_valid is seen.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input bit keep);
    bit          e;
    int          idx, guard, lat, writes, exp_lat;
    logic [31:0] exp_rd, first_a;
    e       = model_err(we, f3, a);
    idx     = int'(a / 4) % 1024;
    exp_rd  = 32'h0;
    exp_lat = e ? 1 : ((we && f3 != 3'd2) ? 3 : 2);
    if (!e) begin
      if (!we) exp_rd = model_load(f3, ref_mem[idx], a);
      else     ref_mem[idx] = model_store(f3, ref_mem[idx], a, wd);
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) check("ready_timeout", 32'(guard), 32'd0);
    @(posedge clk);
    @(negedge clk);
    if (!keep) req_valid = 1'b0;
    first_a = mem_a;
    lat = 1;
    writes = 0;
    while (resp_valid !== 1'b1 && lat < 10) begin
      if (mem_we === 1'b1) writes++;
      check("busy_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      lat++;
    end
    if (mem_we === 1'b1) writes++;
    check("mem_a", first_a, e ? 32'h0 : 32'(idx));
    check("latency", 32'(lat), 32'(exp_lat));
    check("rdata", resp_rdata, exp_rd);
    check("err", 32'(resp_err), 32'(e));
    check("writes", 32'(writes), (e || !we) ? 32'd0 : 32'd1);
    if (!e) check("mem_word", mem[idx], ref_mem[idx]);
  endtask

  logic [31:0] saved;

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    for (int i = 0; i < 64; i++) poke(i, $urandom);
    poke(1023, $urandom);
    poke(7, 32'h00000020);
    poke(10, 32'h00000002);
    poke(3, 32'h80FF1234);
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    do_req(1'b0, 3'd2, 32'd28, 32'h0, 1'b0);
    do_req(1'b0, 3'd0, 32'd12, 32'h0, 1'b0);
    do_req(1'b0, 3'd0, 32'd14, 32'h0, 1'b0);
    do_req(1'b0, 3'd4, 32'd15, 32'h0, 1'b0);
    do_req(1'b0, 3'd1, 32'd14, 32'h0, 1'b0);
    do_req(1'b0, 3'd5, 32'd12, 32'h0, 1'b0);
    do_req(1'b1, 3'd0, 32'd41, 32'h000000AB, 1'b0);
    do_req(1'b0, 3'd2, 32'd40, 32'h0, 1'b0);
    check("sb_merged_value", resp_rdata, 32'h0000AB02);
    do_req(1'b1, 3'd2, 32'd8, 32'hDEADBEEF, 1'b0);
    do_req(1'b0, 3'd2, 32'd30, 32'h0, 1'b0);
    do_req(1'b1, 3'd1, 32'd13, 32'h1234, 1'b0);
    do_req(1'b0, 3'd3, 32'd16, 32'h0, 1'b0);
    do_req(1'b0, 3'd2, 32'd4096, 32'h0, 1'b0);
    do_req(1'b1, 3'd4, 32'd16, 32'h55, 1'b0);
    do_req(1'b0, 3'd2, 32'd4092, 32'h0, 1'b0);

    // Two loads with req_valid never dropped in between.
    do_req(1'b0, 3'd2, 32'd28, 32'h0, 1'b1);
    do_req(1'b0, 3'd0, 32'd15, 32'h0, 1'b0);

    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 15) == 0) ? (32'd4096 + $urandom_range(0, 4000)) : $urandom_range(0, 255);
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, 1'b0);
    end

    // Reset while the SB write is pending in MERGE.
    @(negedge clk);
    saved = mem[11];
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'd0;
    req_addr   = 32'd45;
    req_wdata  = ~saved;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("merge_we_before_rst", 32'(mem_we), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_mem_we", 32'(mem_we), 32'd0);
    check("rst_mid_mem_a", mem_a, 32'h0);
    check("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_word_unchanged", mem[11], saved);
    check("rst_release_ready", 32'(req_ready), 32'd1);
    check("rst_release_mem_we", 32'(mem_we), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
